// File: rtl/stim_pkg.sv
// rtl/stim_pkg.sv - shared states, select codes and default width for the stimulation phase sequencer
package stim_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH0  = 3'd1,
        IPD  = 3'd2,
        PH1  = 3'd3,
        GAP  = 3'd4
    } stim_state_t;

    localparam logic [3:0] SEL_RESET = 4'd0;
    localparam logic [3:0] SEL_DATA0 = 4'd1;
    localparam logic [3:0] SEL_DATA1 = 4'd2;

    // Mux select presented downstream while in a given state.
    function automatic logic [3:0] state_select(input stim_state_t s);
        logic [3:0] sel;
        sel = SEL_RESET;
        case (s)
            PH0:     sel = SEL_DATA0;
            PH1:     sel = SEL_DATA1;
            default: sel = SEL_RESET;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/stim_phase_sequencer_if.sv
// rtl/stim_phase_sequencer_if.sv - control and status bundle between stimulus controller and phase sequencer
interface stim_phase_sequencer_if
    import stim_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic             start;
    logic             stop;
    logic [CNT_W-1:0] phase0_len;
    logic [CNT_W-1:0] phase1_len;
    logic [CNT_W-1:0] gap_len;
    logic [CNT_W-1:0] interphase_len;
    logic [CNT_W-1:0] num_cycles;
    logic [3:0]       select;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, stop, phase0_len, phase1_len, gap_len, interphase_len, num_cycles,
        input  select, busy, done, cycle_count
    );

    modport slave (
        input  start, stop, phase0_len, phase1_len, gap_len, interphase_len, num_cycles,
        output select, busy, done, cycle_count
    );

endinterface

// File: rtl/stim_dwell_counter.sv
// rtl/stim_dwell_counter.sv - per-state dwell timer; flags the last cycle of a timed state
module stim_dwell_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             expire_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;

    // Load remaining-cycles-minus-one on state entry (0 and 1 both mean one cycle), then count down.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= (len_i == '0) ? '0 : (len_i - CNT_ONE);
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_ONE;
        end
    end

    assign expire_o = (count_q == '0);

endmodule

// File: rtl/stim_phase_sequencer.sv
// rtl/stim_phase_sequencer.sv - biphasic stimulation phase sequencer; STIM_SEQ_INTERPHASE_EN adds the interphase hold
module stim_phase_sequencer
    import stim_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    stim_phase_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stim_state_t      state_q, state_d;
    logic [3:0]       select_q;
    logic             busy_q;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    logic [CNT_W-1:0] p0_len_q;
    logic [CNT_W-1:0] p1_len_q;
    logic [CNT_W-1:0] gap_len_q;
    logic [CNT_W-1:0] num_cycles_q;
`ifdef STIM_SEQ_INTERPHASE_EN
    logic [CNT_W-1:0] ip_len_q;
`else
    logic [CNT_W-1:0] unused_interphase_len;
    assign unused_interphase_len = bus.interphase_len;
`endif

    logic             accept_start;
    logic             dwell_load;
    logic [CNT_W-1:0] dwell_len;
    logic             dwell_expire;

    stim_dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (dwell_load),
        .len_i    (dwell_len),
        .expire_o (dwell_expire)
    );

    // Next-state, completion and cycle counting; stop overrides everything and freezes the count.
    always_comb begin
        state_d       = state_q;
        done_d        = 1'b0;
        cycle_count_d = cycle_count_q;
        accept_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d       = PH0;
                    accept_start  = 1'b1;
                    cycle_count_d = '0;
                end
            end
            PH0: begin
                if (dwell_expire) begin
`ifdef STIM_SEQ_INTERPHASE_EN
                    state_d = IPD;
`else
                    state_d = PH1;
`endif
                end
            end
`ifdef STIM_SEQ_INTERPHASE_EN
            IPD: begin
                if (dwell_expire) begin
                    state_d = PH1;
                end
            end
`endif
            PH1: begin
                if (dwell_expire) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (dwell_expire) begin
                    cycle_count_d = cycle_count_q + CNT_ONE;
                    if ((num_cycles_q != '0) && (cycle_count_d == num_cycles_q)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PH0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.stop) begin
            state_d       = IDLE;
            done_d        = 1'b0;
            cycle_count_d = cycle_count_q;
            accept_start  = 1'b0;
        end
    end

    // Reload the dwell timer on every entry into a timed state; PH0 on start uses the live input.
    always_comb begin
        dwell_load = (state_d != state_q) && (state_d != IDLE);
        dwell_len  = '0;
        case (state_d)
            PH0:     dwell_len = accept_start ? bus.phase0_len : p0_len_q;
`ifdef STIM_SEQ_INTERPHASE_EN
            IPD:     dwell_len = ip_len_q;
`endif
            PH1:     dwell_len = p1_len_q;
            GAP:     dwell_len = gap_len_q;
            default: dwell_len = '0;
        endcase
    end

    // Capture the run parameters once at start so later input changes have no effect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_len_q     <= '0;
            p1_len_q     <= '0;
            gap_len_q    <= '0;
            num_cycles_q <= '0;
`ifdef STIM_SEQ_INTERPHASE_EN
            ip_len_q     <= '0;
`endif
        end else if (accept_start) begin
            p0_len_q     <= bus.phase0_len;
            p1_len_q     <= bus.phase1_len;
            gap_len_q    <= bus.gap_len;
            num_cycles_q <= bus.num_cycles;
`ifdef STIM_SEQ_INTERPHASE_EN
            ip_len_q     <= bus.interphase_len;
`endif
        end
    end

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            select_q      <= SEL_RESET;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            select_q      <= state_select(state_d);
            busy_q        <= (state_d != IDLE);
            done_q        <= done_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.select      = select_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_stim_phase_sequencer.sv
// tb/tb_stim_phase_sequencer.sv - scoreboard bench for stim_phase_sequencer
module tb_stim_phase_sequencer;

    typedef struct {
        logic [31:0] sel;
        logic [31:0] busy;
        logic [31:0] done;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   budget   = 0;
    logic [15:0] last_cnt;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    stim_phase_sequencer_if #(.CNT_W(16)) bus ();

    stim_phase_sequencer #(
        .CNT_W (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int sel, input int busy, input int done, input logic [15:0] cnt, input string tag);
        exp_t e;
        e.sel  = sel;
        e.busy = busy;
        e.done = done;
        e.cnt  = {16'd0, cnt};
        e.tag  = tag;
        exp_q.push_back(e);
        last_cnt = cnt;
    endtask

    task automatic seg(input int sel, input int len, input logic [15:0] cnt, input string tag);
        int reps;
        reps = (len == 0) ? 1 : len;
        for (int i = 0; i < reps; i++) begin
            if (budget > 0) begin
                push(sel, 1, 0, cnt, tag);
                budget--;
            end
        end
    endtask

    // Reference trace of one run, truncated to the current budget of cycles.
    task automatic push_run(input int a, input int b, input int g, input int ip, input int n, input string tag);
        logic [15:0] cnt;
        cnt = 16'd0;
        while (budget > 0) begin
            seg(1, a, cnt, tag);
`ifdef STIM_SEQ_INTERPHASE_EN
            seg(0, ip, cnt, tag);
`else
            if (ip < 0) seg(0, 1, cnt, tag);
`endif
            seg(2, b, cnt, tag);
            seg(0, g, cnt, tag);
            cnt = cnt + 16'd1;
            if ((n != 0) && (cnt == 16'(n))) begin
                if (budget > 0) begin
                    push(0, 0, 1, cnt, {tag, ".done"});
                    budget--;
                end
                break;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        if (exp_q.size() != 0) begin
            check_val({tag, ".drain"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic set_run(input int a, input int b, input int g, input int ip, input int n);
        bus.phase0_len     = 16'(a);
        bus.phase1_len     = 16'(b);
        bus.gap_len        = 16'(g);
        bus.interphase_len = 16'(ip);
        bus.num_cycles     = 16'(n);
    endtask

    // Compare each observed cycle against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val({e.tag, ".select"}, {28'd0, bus.select}, e.sel);
            check_val({e.tag, ".busy"},   {31'd0, bus.busy},   e.busy);
            check_val({e.tag, ".done"},   {31'd0, bus.done},   e.done);
            check_val({e.tag, ".count"},  {16'd0, bus.cycle_count}, e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [15:0] prev;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_run(0, 0, 0, 0, 0);
        repeat (3) step();
        push(0, 0, 0, 16'd0, "reset");
        step();
        rst_n = 1'b1;
        push(0, 0, 0, 16'd0, "idle");
        step();
        drain("reset");

        // Two finite cycles 3/2/4; inputs changed after start must be ignored.
        set_run(3, 2, 4, 5, 2);
        bus.start = 1'b1;
        push(0, 0, 0, 16'd0, "t2.pre");
        budget = 1000;
        push_run(3, 2, 4, 5, 2, "t2");
        step();
        bus.start = 1'b0;
        set_run(7, 7, 7, 7, 9);
        drain("t2");
        prev = last_cnt;

        // Continuous run 1/1/1, stop after ten cycles.
        set_run(1, 1, 1, 1, 0);
        bus.start = 1'b1;
        push(0, 0, 0, prev, "t3.pre");
        budget = 10;
        push_run(1, 1, 1, 1, 0, "t3");
        step();
        bus.start = 1'b0;
        repeat (9) step();
        bus.stop = 1'b1;
        push(0, 0, 0, 16'd3, "t3.stop");
        step();
        bus.stop = 1'b0;
        push(0, 0, 0, 16'd3, "t3.hold");
        step();
        drain("t3");

        // Zero lengths behave as one cycle each.
        set_run(0, 0, 0, 0, 1);
        bus.start = 1'b1;
        push(0, 0, 0, 16'd3, "t4.pre");
        budget = 1000;
        push_run(0, 0, 0, 0, 1, "t4");
        step();
        bus.start = 1'b0;
        drain("t4");

        // start and stop together in IDLE: stop wins.
        set_run(2, 2, 2, 2, 1);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        push(0, 0, 0, 16'd1, "t5.pre");
        push(0, 0, 0, 16'd1, "t5.ss");
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        push(0, 0, 0, 16'd1, "t5.idle");
        step();
        drain("t5");

        // start during PH1 is ignored.
        set_run(2, 3, 1, 1, 1);
        bus.start = 1'b1;
        push(0, 0, 0, 16'd1, "t6.pre");
        budget = 1000;
        push_run(2, 3, 1, 1, 1, "t6");
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.start = 1'b1;
        set_run(5, 5, 5, 5, 3);
        step();
        bus.start = 1'b0;
        drain("t6");

        // Interphase hold of two with 1/1/1 (collapses to 1,2,0 when the hold is not built).
        set_run(1, 1, 1, 2, 1);
        bus.start = 1'b1;
        push(0, 0, 0, 16'd1, "t7.pre");
        budget = 1000;
        push_run(1, 1, 1, 2, 1, "t7");
        step();
        bus.start = 1'b0;
        drain("t7");

        // Reset asserted mid-PH0 of the second cycle of a continuous run.
        set_run(3, 1, 1, 1, 0);
        bus.start = 1'b1;
        push(0, 0, 0, 16'd1, "t8.pre");
        budget = 7;
        push_run(3, 1, 1, 1, 0, "t8");
        step();
        bus.start = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        push(0, 0, 0, 16'd0, "t8.rst");
        step();
        rst_n = 1'b1;
        push(0, 0, 0, 16'd0, "t8.after");
        step();
        drain("t8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
